instr_sequencer: RTL

// - Upstream control stage for the 8x16 register file: holds the current 16-bit instruction,

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/instr_decoder.sv | 25 ++
 rtl/instr_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and datapath-control encodings for the instruction sequencer
package cpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        ALU,
        WB_REG,
        WR_IMM
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

    // Sign-extend an 8-bit field to the 16-bit datapath width
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Sign-extend a 5-bit field to the 16-bit datapath width
    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - instruction field extraction and immediate sign-extension
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = sext8(ir[7:0]);
    assign sximm5 = sext5(ir[4:0]);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction register, control FSM and Moore output decode
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_t      state;
    logic [15:0] ir;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;

    instr_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_mvn;
    logic is_cmp;

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

    // IR capture (only while idle) and state transitions; reset drops any in-flight writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            ir    <= 16'h0000;
        end else begin
            case (state)
                WAIT: begin
                    if (load)
                        ir <= in;
                    if (s)
                        state <= DECODE;
                end
                DECODE: begin
                    if (is_mov_imm)
                        state <= WR_IMM;
                    else if (is_mov_reg || is_mvn)
                        state <= GET_B;
                    else if (opcode == OPC_ALU)
                        state <= GET_A;
                    else
                        state <= WAIT;
                end
                GET_A:   state <= GET_B;
                GET_B:   state <= ALU;
                ALU:     state <= is_cmp ? WAIT : WB_REG;
                WB_REG:  state <= WAIT;
                WR_IMM:  state <= WAIT;
                default: state <= WAIT;
            endcase
        end
    end

    // Moore output decode from state and the held instruction
    always_comb begin
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        case (state)
            WAIT: w = 1'b1;
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ALU: begin
                shift = sh;
                // Single-operand ops pass B through against a zeroed A
                asel  = is_mov_reg || is_mvn;
                ALUop = is_mov_reg ? ALU_ADD : op;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            WB_REG: begin
                writenum = rd;
                write    = 1'b1;
                vsel     = VSEL_C;
            end
            WR_IMM: begin
                writenum = rn;
                write    = 1'b1;
                vsel     = VSEL_IMM8;
            end
            default: ;
        endcase
    end

endmodule
